key_press_classifier: RTL and testbench



---
 rtl/key_pkg.sv | 42 ++++
 rtl/key_debounce.sv | 58 +++++
 rtl/key_press_classifier.sv | 99 +++++++++
 tb/tb_key_press_classifier.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared mode codes, 7-segment table and helpers for key_press_classifier
package key_pkg;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;

   localparam logic [0:6] SEG_BLANK = 7'b1111111;

   // Active-low segments, index 0 = segment a through index 6 = segment g
   function automatic logic [0:6] seg_digit(input logic [3:0] d);
      case (d)
         4'd0:    seg_digit = 7'b0000001;
         4'd1:    seg_digit = 7'b1001111;
         4'd2:    seg_digit = 7'b0010010;
         4'd3:    seg_digit = 7'b0000110;
         4'd4:    seg_digit = 7'b1001100;
         4'd5:    seg_digit = 7'b0100100;
         4'd6:    seg_digit = 7'b0100000;
         4'd7:    seg_digit = 7'b0001111;
         4'd8:    seg_digit = 7'b0000000;
         4'd9:    seg_digit = 7'b0000100;
         default: seg_digit = SEG_BLANK;
      endcase
   endfunction

   function automatic logic [3:0] whole_seconds(input logic [31:0] ms);
      logic [3:0] s;
      s = 4'd0;
      for (int i = 1; i <= 9; i++) begin
         if (ms >= 32'(i * 1000)) s = 4'(i);
      end
      return s;
   endfunction

   function automatic logic [1:0] classify(input logic [31:0] dur, input int left_min, input int right_min);
      if (dur < 32'(left_min))       classify = MODE_HOLD;
      else if (dur < 32'(right_min)) classify = MODE_LEFT;
      else                           classify = MODE_RIGHT;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - KEY synchronizer, ms prescaler and tick-based debouncer
// press_acc_o/rel_acc_o fire combinationally on the edge where key_db_o changes.
module key_debounce #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int DEBOUNCE_MS = 20
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic key_db_o,
   output logic press_acc_o,
   output logic rel_acc_o,
   output logic tick_o
);

   localparam int PRE_TERM = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 - 1 : 0;
   localparam int PRE_W    = (PRE_TERM > 0) ? $clog2(PRE_TERM + 1) : 1;
   localparam int DB_W     = $clog2(DEBOUNCE_MS + 1);

   logic [1:0]       sync_q;
   logic [PRE_W-1:0] pre_q;
   logic [DB_W-1:0]  db_cnt_q;
   logic             db_q;
   logic             key_s;
   logic             accept;

   assign key_s  = sync_q[1];
   assign tick_o = (pre_q == PRE_W'(PRE_TERM));
   assign accept = tick_o && (key_s != db_q) && (db_cnt_q == DB_W'(DEBOUNCE_MS - 1));

   assign key_db_o    = db_q;
   assign press_acc_o = accept && !key_s;
   assign rel_acc_o   = accept && key_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= 2'b11;
         pre_q    <= '0;
         db_cnt_q <= '0;
         db_q     <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], key_i};
         pre_q  <= tick_o ? '0 : pre_q + PRE_W'(1);
         // Any return to the accepted level restarts the persistence count
         if (key_s == db_q) begin
            db_cnt_q <= '0;
         end else if (tick_o) begin
            if (accept) begin
               db_q     <= key_s;
               db_cnt_q <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + DB_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/key_press_classifier.sv
// rtl/key_press_classifier.sv - measures debounced KEY hold time and classifies it as HOLD/LEFT/RIGHT
// HOLD_SECONDS_DISPLAY_EN adds HEX0, a 7-segment display of whole seconds held.
module key_press_classifier
   import key_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int DEBOUNCE_MS  = 20,
   parameter int LEFT_MIN_MS  = 2000,
   parameter int RIGHT_MIN_MS = 4000,
   parameter int DUR_W        = 14
) (
   input  logic             CLOCK_50Mhz,
   input  logic             RESET_N,
   input  logic             KEY,
   output logic             KEY_DB,
   output logic [1:0]       MODE,
   output logic             MODE_VALID,
   output logic [DUR_W-1:0] DURATION_MS
`ifdef HOLD_SECONDS_DISPLAY_EN
   ,
   output logic [0:6]       HEX0
`endif
);

   typedef enum logic {IDLE, PRESSED} state_t;

   state_t           state_q;
   logic [DUR_W-1:0] dur_cnt_q;
   logic [DUR_W-1:0] dur_out_q;
   logic [1:0]       mode_q;
   logic             valid_q;
   logic             press_acc;
   logic             rel_acc;
   logic             tick;

   key_debounce #(
      .CLK_HZ      (CLK_HZ),
      .DEBOUNCE_MS (DEBOUNCE_MS)
   ) u_debounce (
      .clk_i       (CLOCK_50Mhz),
      .rst_ni      (RESET_N),
      .key_i       (KEY),
      .key_db_o    (KEY_DB),
      .press_acc_o (press_acc),
      .rel_acc_o   (rel_acc),
      .tick_o      (tick)
   );

   always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         dur_cnt_q <= '0;
         dur_out_q <= '0;
         mode_q    <= MODE_HOLD;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (press_acc) begin
                  dur_cnt_q <= '0;
                  state_q   <= PRESSED;
               end
            end
            PRESSED: begin
               // The tick coinciding with release acceptance is deliberately dropped
               if (rel_acc) begin
                  dur_out_q <= dur_cnt_q;
                  mode_q    <= classify(32'(dur_cnt_q), LEFT_MIN_MS, RIGHT_MIN_MS);
                  valid_q   <= 1'b1;
                  state_q   <= IDLE;
               end else if (tick && (dur_cnt_q != '1)) begin
                  dur_cnt_q <= dur_cnt_q + DUR_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign MODE        = mode_q;
   assign MODE_VALID  = valid_q;
   assign DURATION_MS = dur_out_q;

`ifdef HOLD_SECONDS_DISPLAY_EN
   logic [0:6] hex_q;

   always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
      if (!RESET_N) begin
         hex_q <= seg_digit(4'd0);
      end else begin
         hex_q <= seg_digit(whole_seconds(32'((state_q == PRESSED) ? dur_cnt_q : dur_out_q)));
      end
   end

   assign HEX0 = hex_q;
`endif

endmodule

// File: tb/tb_key_press_classifier.sv
// tb/tb_key_press_classifier.sv - randomized self-checking bench for key_press_classifier
// Runs with CLK_HZ=1000 (one ms tick per cycle) and DEBOUNCE_MS=3.
module tb_key_press_classifier;

   localparam int DUR_W   = 14;
   localparam int DUR_MAX = (1 << DUR_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             key;
   logic             key_db;
   logic [1:0]       mode;
   logic             mode_valid;
   logic [DUR_W-1:0] duration_ms;
`ifdef HOLD_SECONDS_DISPLAY_EN
   logic [0:6]       hex0;
`endif

   int errors     = 0;
   int checks     = 0;
   int strobe_cnt = 0;

   key_press_classifier #(
      .CLK_HZ       (1000),
      .DEBOUNCE_MS  (3),
      .LEFT_MIN_MS  (2000),
      .RIGHT_MIN_MS (4000),
      .DUR_W        (DUR_W)
   ) dut (
      .CLOCK_50Mhz (clk),
      .RESET_N     (rst_n),
      .KEY         (key),
      .KEY_DB      (key_db),
      .MODE        (mode),
      .MODE_VALID  (mode_valid),
      .DURATION_MS (duration_ms)
`ifdef HOLD_SECONDS_DISPLAY_EN
      ,
      .HEX0        (hex0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mode_valid === 1'b1) strobe_cnt++;
   end

   // Reference: the count spans the ticks strictly between press and release
   // acceptance, which are equally delayed, so it is one less than the number
   // of clock edges that sample KEY low, saturating at the counter ceiling.
   function automatic logic [DUR_W-1:0] model_dur(input int low_edges);
      int d;
      d = low_edges - 1;
      if (d > DUR_MAX) d = DUR_MAX;
      return DUR_W'(d);
   endfunction

   function automatic logic [1:0] model_mode(input int d);
      if (d < 2000)      return 2'b00;
      else if (d < 4000) return 2'b01;
      else               return 2'b10;
   endfunction

   task automatic hold_key(input int n);
      @(negedge clk);
      key = 1'b0;
      repeat (n) @(negedge clk);
      key = 1'b1;
   endtask

   task automatic wait_strobe(input int bound, output bit seen, output logic [1:0] m,
                              output logic [DUR_W-1:0] d, output bit single);
      seen   = 1'b0;
      single = 1'b0;
      m      = 2'b00;
      d      = '0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (mode_valid === 1'b1) begin
            seen = 1'b1;
            m    = mode;
            d    = duration_ms;
         end
      end
      if (seen) begin
         @(negedge clk);
         single = (mode_valid === 1'b0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      key   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (key_db !== 1'b1) begin errors++; $display("FAIL reset_key_db: got %b want 1", key_db); end
         checks++;
         if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b want 00", mode); end
         checks++;
         if (mode_valid !== 1'b0) begin errors++; $display("FAIL reset_mode_valid: got %b want 0", mode_valid); end
         checks++;
         if (duration_ms !== '0) begin errors++; $display("FAIL reset_duration: got %0d want 0", duration_ms); end
      end
      key = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_glitch();
      int len;
      int base;
      bit db_moved;
      for (int g = 0; g < 4; g++) begin
         len      = $urandom_range(1, 2);
         base     = strobe_cnt;
         db_moved = 1'b0;
         @(negedge clk);
         key = 1'b0;
         repeat (len) begin
            @(negedge clk);
            if (key_db !== 1'b1) db_moved = 1'b1;
         end
         key = 1'b1;
         repeat (50) begin
            @(negedge clk);
            if (key_db !== 1'b1) db_moved = 1'b1;
         end
         checks++;
         if (db_moved) begin errors++; $display("FAIL glitch_key_db: len=%0d key_db left 1", len); end
         checks++;
         if (strobe_cnt != base) begin errors++; $display("FAIL glitch_strobe: got %0d strobes want 0", strobe_cnt - base); end
      end
   endtask

   task automatic test_short_press();
      bit               seen, single;
      logic [1:0]       m;
      logic [DUR_W-1:0] d;
      @(negedge clk);
      key = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (key_db !== 1'b1) begin errors++; $display("FAIL short_db_early: got %b want 1 four cycles after press", key_db); end
      @(negedge clk);
      checks++;
      if (key_db !== 1'b0) begin errors++; $display("FAIL short_db_fall: got %b want 0 five cycles after press", key_db); end
      repeat (501 - 5) @(negedge clk);
      key = 1'b1;
      wait_strobe(20, seen, m, d, single);
      checks++;
      if (!seen) begin errors++; $display("FAIL short_strobe: no MODE_VALID within 20 cycles"); end
      checks++;
      if (!single) begin errors++; $display("FAIL short_single: MODE_VALID width got >1 or missing, want 1 cycle"); end
      checks++;
      if (m !== 2'b00) begin errors++; $display("FAIL short_mode: got %b want 00", m); end
      checks++;
      if (d !== model_dur(501)) begin errors++; $display("FAIL short_duration: got %0d want %0d", d, model_dur(501)); end
      repeat (10) @(negedge clk);
      checks++;
      if (mode !== 2'b00 || duration_ms !== DUR_W'(500)) begin
         errors++; $display("FAIL short_hold: got mode=%b dur=%0d want 00/500", mode, duration_ms);
      end
   endtask

   task automatic test_boundaries();
      int               targets[4] = '{1999, 2000, 3999, 4000};
      bit               seen, single;
      logic [1:0]       m;
      logic [DUR_W-1:0] d;
      int               base;
      foreach (targets[i]) begin
         base = strobe_cnt;
         hold_key(targets[i] + 1);
         wait_strobe(20, seen, m, d, single);
         checks++;
         if (!seen || !single || strobe_cnt != base + 1) begin
            errors++; $display("FAIL boundary_strobe_%0d: seen=%b single=%b strobes=%0d want 1", targets[i], seen, single, strobe_cnt - base);
         end
         checks++;
         if (d !== DUR_W'(targets[i])) begin errors++; $display("FAIL boundary_dur_%0d: got %0d want %0d", targets[i], d, targets[i]); end
         checks++;
         if (m !== model_mode(targets[i])) begin errors++; $display("FAIL boundary_mode_%0d: got %b want %b", targets[i], m, model_mode(targets[i])); end
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic test_random();
      bit               seen, single;
      logic [1:0]       m;
      logic [DUR_W-1:0] d;
      int               n;
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(10, 4500);
         hold_key(n);
         wait_strobe(20, seen, m, d, single);
         checks++;
         if (!seen || !single) begin errors++; $display("FAIL random_strobe_%0d: seen=%b single=%b", n, seen, single); end
         checks++;
         if (d !== model_dur(n)) begin errors++; $display("FAIL random_dur_%0d: got %0d want %0d", n, d, model_dur(n)); end
         checks++;
         if (m !== model_mode(int'(model_dur(n)))) begin
            errors++; $display("FAIL random_mode_%0d: got %b want %b", n, m, model_mode(int'(model_dur(n))));
         end
         repeat ($urandom_range(8, 30)) @(negedge clk);
      end
   endtask

   task automatic test_saturation();
      bit               seen, single;
      logic [1:0]       m;
      logic [DUR_W-1:0] d;
      int               base;
      base = strobe_cnt;
      hold_key(20000);
      wait_strobe(20, seen, m, d, single);
      repeat (10) @(negedge clk);
      checks++;
      if (!seen || strobe_cnt != base + 1) begin errors++; $display("FAIL sat_strobe: got %0d strobes want 1", strobe_cnt - base); end
      checks++;
      if (d !== DUR_W'(DUR_MAX)) begin errors++; $display("FAIL sat_dur: got %0d want %0d", d, DUR_MAX); end
      checks++;
      if (m !== 2'b10) begin errors++; $display("FAIL sat_mode: got %b want 10", m); end
   endtask

   task automatic test_reset_mid_press();
      bit               seen, single;
      logic [1:0]       m;
      logic [DUR_W-1:0] d;
      int               base;
      base = strobe_cnt;
      @(negedge clk);
      key = 1'b0;
      repeat (1495) @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (duration_ms !== '0 || key_db !== 1'b1) begin
         errors++; $display("FAIL midreset_state: got dur=%0d key_db=%b want 0/1", duration_ms, key_db);
      end
      rst_n = 1'b1;
      repeat (1010) @(negedge clk);
      checks++;
      if (strobe_cnt != base) begin errors++; $display("FAIL midreset_nostrobe: got %0d strobes want 0", strobe_cnt - base); end
`ifdef HOLD_SECONDS_DISPLAY_EN
      checks++;
      if (hex0 !== 7'b1001111) begin errors++; $display("FAIL midreset_hex: got %b want 1001111", hex0); end
`endif
      key = 1'b1;
      wait_strobe(20, seen, m, d, single);
      checks++;
      if (!seen || !single) begin errors++; $display("FAIL midreset_strobe: seen=%b single=%b", seen, single); end
      checks++;
      if (d !== model_dur(1010)) begin errors++; $display("FAIL midreset_dur: got %0d want %0d", d, model_dur(1010)); end
      checks++;
      if (m !== 2'b00) begin errors++; $display("FAIL midreset_mode: got %b want 00", m); end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      key   = 1'b1;
      test_reset();
      test_glitch();
      test_short_press();
      test_boundaries();
      test_random();
      test_saturation();
      test_reset_mid_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
